// File: rtl/vga_timing_pkg.sv
// Timing constants and shared types for the 640x480@60 raster generator.
// Build option: VGA_FRAME_CNT_EN (frame counter, handled in vga_sync_gen).
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic SYNC_POL = 1'b0;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic vnotactive;
    logic frame_start;
  } vga_flags_t;

  localparam vga_flags_t FLAGS_RST = '{
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    active:      1'b0,
    vnotactive:  1'b0,
    frame_start: 1'b0
  };

  function automatic logic in_range(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-enable input and raster outputs of the sync generator, bundled for the display path.
interface vga_sync_gen_if;
  logic                   CE;
  logic                   hsync;
  logic                   vsync;
  vga_timing_pkg::coord_t col;
  vga_timing_pkg::coord_t row;
  logic                   active;
  logic                   vnotactive;
  logic                   frame_start;
  logic [15:0]            frame_cnt;

  modport master (
    input  CE,
    output hsync, vsync, col, row, active, vnotactive, frame_start, frame_cnt
  );

  modport slave (
    output CE,
    input  hsync, vsync, col, row, active, vnotactive, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each inc and flags the last position.
// Wrap uses an equality compare, so TOTAL must not exceed 1024.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   inc,
  output coord_t count,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t count_q, count_d;

  assign wrap  = (count_q == LAST);
  assign count = count_q;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (inc) count_d = wrap ? '0 : count_q + 10'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running raster timing generator: axis counters plus registered pixel decode.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_LEN        = H_TOTAL,
  parameter int H_VISIBLE    = H_VIS,
  parameter int H_SYNC_BEGIN = H_SYNC_START,
  parameter int H_SYNC_LAST  = H_SYNC_END,
  parameter int V_LEN        = V_TOTAL,
  parameter int V_VISIBLE    = V_VIS,
  parameter int V_SYNC_BEGIN = V_SYNC_START,
  parameter int V_SYNC_LAST  = V_SYNC_END
) (
  input  logic           CLK,
  input  logic           RST,
  vga_sync_gen_if.master vga
);

  coord_t     hcnt, vcnt;
  logic       h_wrap, v_wrap, v_inc;
  coord_t     col_q, row_q;
  vga_flags_t flags_d, flags_q;

  assign v_inc = vga.CE & h_wrap;

  vga_axis_counter #(.TOTAL(H_LEN)) u_hcnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (vga.CE),
    .count (hcnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_LEN)) u_vcnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (v_inc),
    .count (vcnt),
    .wrap  (v_wrap)
  );

  // Decode the pre-advance counters; the register below makes every output describe (col,row).
  always_comb begin
    flags_d             = FLAGS_RST;
    flags_d.hsync       = in_range(hcnt, H_SYNC_BEGIN, H_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    flags_d.vsync       = in_range(vcnt, V_SYNC_BEGIN, V_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    flags_d.active      = (int'(hcnt) < H_VISIBLE) && (int'(vcnt) < V_VISIBLE);
    flags_d.vnotactive  = (int'(vcnt) >= V_VISIBLE);
    flags_d.frame_start = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col_q   <= '0;
      row_q   <= '0;
      flags_q <= FLAGS_RST;
    end else if (vga.CE) begin
      col_q   <= hcnt;
      row_q   <= vcnt;
      flags_q <= flags_d;
    end
  end

  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.hsync       = flags_q.hsync;
  assign vga.vsync       = flags_q.vsync;
  assign vga.active      = flags_q.active;
  assign vga.vnotactive  = flags_q.vnotactive;
  assign vga.frame_start = flags_q.frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts the edge that leaves the last pixel of the frame; wraps naturally at 2^16.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          frame_cnt_q <= '0;
    else if (vga.CE && h_wrap && v_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign vga.frame_cnt = frame_cnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
  assign vga.frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised CE stimulus on a full-size and a shrunken raster, checked against a pixel-index model.
module tb_vga_sync_gen;

  typedef struct {
    int ht, hv, hss, hse;
    int vt, vv, vss, vse;
  } tim_t;

  typedef struct {
    int col, row;
    bit hs, vs, act, vna, fs;
    int fc;
  } exp_t;

  localparam tim_t T_F = '{800, 640, 656, 751, 525, 480, 490, 491};
  localparam tim_t T_S = '{25, 16, 18, 21, 19, 12, 14, 15};

`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k_f, k_s;
  int   fc_base_s;

  always #5 clk = ~clk;

  vga_sync_gen_if if_f ();
  vga_sync_gen_if if_s ();

  vga_sync_gen dut_f (
    .CLK (clk),
    .RST (rst),
    .vga (if_f)
  );

  vga_sync_gen #(
    .H_LEN(25), .H_VISIBLE(16), .H_SYNC_BEGIN(18), .H_SYNC_LAST(21),
    .V_LEN(19), .V_VISIBLE(12), .V_SYNC_BEGIN(14), .V_SYNC_LAST(15)
  ) dut_s (
    .CLK (clk),
    .RST (rst),
    .vga (if_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // After k CE edges since reset the outputs show pixel (k-1) of the raster, frames counted by k/frame.
  function automatic exp_t model(input int k, input tim_t t, input int fc_base);
    exp_t e;
    int frame, idx;
    frame = t.ht * t.vt;
    if (k == 0) begin
      e = '{0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (FC_EN ? fc_base : 0)};
      return e;
    end
    idx   = (k - 1) % frame;
    e.col = idx % t.ht;
    e.row = idx / t.ht;
    e.hs  = !(e.col >= t.hss && e.col <= t.hse);
    e.vs  = !(e.row >= t.vss && e.row <= t.vse);
    e.act = (e.col < t.hv) && (e.row < t.vv);
    e.vna = (e.row >= t.vv);
    e.fs  = (idx == 0);
    e.fc  = FC_EN ? ((fc_base + k / frame) % 65536) : 0;
    return e;
  endfunction

  task automatic check_dut(input string who, input exp_t e,
                           input logic [9:0] col, input logic [9:0] row,
                           input logic hs, input logic vs, input logic act,
                           input logic vna, input logic fs, input logic [15:0] fc);
    check({who, ".col"},         col, e.col);
    check({who, ".row"},         row, e.row);
    check({who, ".hsync"},       hs,  e.hs);
    check({who, ".vsync"},       vs,  e.vs);
    check({who, ".active"},      act, e.act);
    check({who, ".vnotactive"},  vna, e.vna);
    check({who, ".frame_start"}, fs,  e.fs);
    check({who, ".frame_cnt"},   fc,  e.fc);
  endtask

  task automatic check_both();
    check_dut("full", model(k_f, T_F, 0), if_f.col, if_f.row, if_f.hsync, if_f.vsync,
              if_f.active, if_f.vnotactive, if_f.frame_start, if_f.frame_cnt);
    check_dut("small", model(k_s, T_S, fc_base_s), if_s.col, if_s.row, if_s.hsync, if_s.vsync,
              if_s.active, if_s.vnotactive, if_s.frame_start, if_s.frame_cnt);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick(input bit ce_f, input bit ce_s);
    if_f.CE = ce_f;
    if_s.CE = ce_s;
    @(posedge clk);
    if (ce_f) k_f++;
    if (ce_s) k_s++;
    @(negedge clk);
    check_both();
  endtask

  // Reset is raised between edges and checked 1 ns later, before any clock edge.
  task automatic do_reset();
    if_f.CE   = 1'b0;
    if_s.CE   = 1'b0;
    rst       = 1'b1;
    k_f       = 0;
    k_s       = 0;
    fc_base_s = 0;
    #1;
    check_both();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_both();
  endtask

  initial begin
    int hs_low, vna_cnt, vs_low, fs_cnt;
    rst       = 1'b1;
    if_f.CE   = 1'b0;
    if_s.CE   = 1'b0;
    k_f       = 0;
    k_s       = 0;
    fc_base_s = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_both();

    // First pixel after reset.
    tick(1'b1, 1'b1);
    check("first.col",         if_f.col, 0);
    check("first.active",      if_f.active, 1);
    check("first.frame_start", if_f.frame_start, 1);
    check("first.hsync",       if_f.hsync, 1);
    check("first.vsync",       if_f.vsync, 1);

    // One full line on the real raster, one full frame on the small one.
    do_reset();
    hs_low  = 0;
    vna_cnt = 0;
    vs_low  = 0;
    fs_cnt  = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1, i < 475);
      if (!if_f.hsync) hs_low++;
      if (i < 475) begin
        if (if_s.vnotactive) vna_cnt++;
        if (!if_s.vsync) vs_low++;
        if (if_s.frame_start) fs_cnt++;
      end
    end
    check("line.hsync_low_ce", hs_low, 96);
    check("frame.vblank_ce",   vna_cnt, 7 * 25);
    check("frame.vsync_low_ce", vs_low, 2 * 25);
    check("frame.start_pulses", fs_cnt, 1);
    tick(1'b1, 1'b0);
    check("line.wrap_col", if_f.col, 0);
    check("line.wrap_row", if_f.row, 1);

    // Random pixel enables, independently on each instance.
    for (int i = 0; i < 20000; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Mid-frame asynchronous reset, then alternating CE: one line spans 1600 clocks.
    do_reset();
    for (int i = 0; i < 1602; i++) tick(i % 2 == 0, i % 2 == 0);
    check("alt.line_col", if_f.col, 0);
    check("alt.line_row", if_f.row, 1);

`ifdef VGA_FRAME_CNT_EN
    do_reset();
    force dut_s.frame_cnt_q = 16'hFFFE;
    fc_base_s = 65534;
    tick(1'b0, 1'b0);
    release dut_s.frame_cnt_q;
    for (int i = 0; i < 3 * 475; i++) tick(1'b1, 1'b1);
    check("fc.wrapped", if_s.frame_cnt, 1);
`else
    for (int i = 0; i < 3 * 475; i++) tick(1'b1, 1'b1);
    check("fc.tied_zero", if_s.frame_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
